scan_tester: RTL and testbench
==============================

SCAN_TESTER -- requirements
Module: scan_tester

Interface
REQ-001 Parameter CHAIN_LEN, default 2, number of flops in the target scan chain (>=1).
REQ-002 Parameter CAP_CYCLES, default 1, functional-mode capture cycles between shift-in and shift-out (>=1).
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request one test; accepted only in IDLE.
REQ-006 abort  input  1  terminate the current test and return to IDLE.
REQ-007 pattern  input  CHAIN_LEN  stimulus to load into the chain; sampled when start is accepted.
REQ-008 expected  input  CHAIN_LEN  golden response; sampled when start is accepted.
REQ-009 scan_en  output  1  scan-enable to the target chain.
REQ-010 scan_in  output  1  serial data to the target chain.
REQ-011 scan_out  input  1  serial data from the target chain's last flop.
REQ-012 busy  output  1  high from the cycle after start is accepted until the cycle done is high.
REQ-013 done  output  1  one-cycle pulse at test completion.
REQ-014 pass  output  1  response==expected for the last completed test; valid from done until the next done.
REQ-015 response  output  CHAIN_LEN  captured chain contents from the last completed test.
REQ-016 pattern_count  output  8  completed tests; wraps 255->0.
REQ-017 fail_count  output  8  failed tests; saturates at 255.

Function
REQ-018 The FSM SHALL have states IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
REQ-019 IDLE: scan_en=0, scan_in=0; start=1 -> SHIFT_IN, latching pattern and expected.
REQ-020 SHIFT_IN: scan_en=1 for exactly CHAIN_LEN cycles; scan_in drives pattern[CHAIN_LEN-1] first, pattern[0] last; then -> CAPTURE.
REQ-021 CAPTURE: scan_en=0, scan_in=0 for exactly CAP_CYCLES cycles; then -> SHIFT_OUT.
REQ-022 SHIFT_OUT: scan_en=1, scan_in=0 for exactly CHAIN_LEN cycles; scan_out is sampled at each shift edge, the first sample landing in response[CHAIN_LEN-1] and the last in response[0]; then -> DONE.
REQ-023 DONE: done=1 and scan_en=0 for one cycle; pass, response and counters update at this cycle; then -> IDLE.
REQ-024 Latency: done SHALL be asserted exactly 2*CHAIN_LEN+CAP_CYCLES+1 cycles after the edge accepting start.
REQ-025 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-026 abort in any non-IDLE state SHALL go to IDLE on the next edge with scan_en=0 and no done; pass, response and counters keep their prior values.
REQ-027 abort and start together in IDLE SHALL leave the FSM in IDLE (abort wins).
REQ-028 Internal counters SHALL be sized ceil(log2(max(CHAIN_LEN,CAP_CYCLES)+1)) bits and SHALL NOT wrap within a phase.

Reset
REQ-029 rst SHALL force IDLE, scan_en=0, scan_in=0, busy=0, done=0, pass=0, response=0, pattern_count=0, fail_count=0.
REQ-030 rst mid-test SHALL take priority over abort and start and SHALL discard the test in progress.

Structure
REQ-031 A shared package scan_pkg SHALL hold the FSM state enum and the counter-width function.
REQ-032 The serial shift register (parallel load, serial out, serial in, parallel read) SHALL be one sub-module, scan_shift_reg, used for both stimulus and response.

Verification (bench models the chain as a CHAIN_LEN shift register; capture loads {a&b, a^b})
REQ-033 CHAIN_LEN=2, pattern=2'b10, capture a=1,b=1, expected=2'b10 -> scan_in sequence 1,0; response=2'b10; pass=1; done exactly 6 cycles after start.
REQ-034 Capture a=0,b=1 (response 2'b01), expected=2'b10 -> pass=0; fail_count=1; pattern_count=1.
REQ-035 start pulsed again during SHIFT_OUT -> ignored; exactly one done; pattern_count increments by 1.
REQ-036 abort asserted in CAPTURE -> scan_en=0 next cycle; no done; counters and pass unchanged; a new start then runs normally.
REQ-037 rst asserted in SHIFT_IN -> all outputs take reset values at the next edge; busy=0.
REQ-038 256 consecutive failing tests -> pattern_count wraps to 0; fail_count holds 255.

Source files
------------

// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scan_pkg
//  Purpose  : Shared types and helpers for the scan chain tester: FSM state
//             encoding and the phase-counter width function.
//  Revision : 1.0  initial release
// ============================================================================
package scan_pkg;

  // Tester FSM states, 3-bit explicit encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_IN  = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_SHIFT_OUT = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Bits needed to hold any phase length: ceil(log2(max(chain_len,cap_cycles)+1))
  function automatic int cnt_width(input int chain_len, input int cap_cycles);
    int longest;
    longest = (chain_len > cap_cycles) ? chain_len : cap_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage : scan_pkg
`default_nettype wire

// File: rtl/scan_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : scan_shift_reg
//  Purpose  : Parallel-load / serial-in / serial-out shift register. Shifts
//             towards the MSB; the MSB is the serial output. Used both to
//             serialise the stimulus and to assemble the captured response.
//  Revision : 1.0  initial release
// ============================================================================
module scan_shift_reg #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [WIDTH-1:0] q_shift
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Value the register would hold after one shift; a 1-bit register simply
  // takes the serial input
  generate
    if (WIDTH == 1) begin : g_single
      assign q_shift = sin;
    end else begin : g_multi
      assign q_shift = {data_q[WIDTH-2:0], sin};
    end
  endgenerate

  // Next-state select: load has priority over shift
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift) begin
      data_d = q_shift;
    end
  end

  // Register update
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q    = data_q;
  assign sout = data_q[WIDTH-1];

endmodule : scan_shift_reg
`default_nettype wire

// File: rtl/scan_tester.sv
`default_nettype none
// ============================================================================
//  Module   : scan_tester
//  Purpose  : Drives one scan test on an external chain: shift the pattern
//             in, release for CAP_CYCLES functional captures, shift the
//             response out, compare with the golden value and keep counts.
//  Revision : 1.0  initial release
// ============================================================================
module scan_tester
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN  = 2,
  parameter int CAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] response,
  output logic [7:0]           pattern_count,
  output logic [7:0]           fail_count
);

  localparam int             CW         = cnt_width(CHAIN_LEN, CAP_CYCLES);
  localparam logic [CW-1:0]  LAST_SHIFT = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0]  LAST_CAP   = CW'(CAP_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

  state_e               state_q,  state_d;
  logic [CW-1:0]        cnt_q,    cnt_d;
  logic [CHAIN_LEN-1:0] exp_q,    exp_d;
  logic                 pass_q,   pass_d;
  logic [CHAIN_LEN-1:0] resp_q,   resp_d;
  logic [7:0]           pcount_q, pcount_d;
  logic [7:0]           fcount_q, fcount_d;

  logic                 stim_load;
  logic                 stim_shift;
  logic                 resp_shift;
  logic                 finish;

  logic [CHAIN_LEN-1:0] stim_q;
  logic [CHAIN_LEN-1:0] stim_next;
  logic                 stim_sout;
  logic [CHAIN_LEN-1:0] cap_q;
  logic [CHAIN_LEN-1:0] cap_next;
  logic                 cap_sout;
  logic                 unused_sink;

  // Stimulus serialiser: loaded on start, MSB leaves first
  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_stim (
    .clk      (clk),
    .rst      (rst),
    .load     (stim_load),
    .load_val (pattern),
    .shift    (stim_shift),
    .sin      (1'b0),
    .q        (stim_q),
    .sout     (stim_sout),
    .q_shift  (stim_next)
  );

  // Response assembler: first bit out of the chain ends up in the MSB
  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_resp (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .shift    (resp_shift),
    .sin      (scan_out),
    .q        (cap_q),
    .sout     (cap_sout),
    .q_shift  (cap_next)
  );

  // Sub-module outputs this level does not consume are folded into one sink
  assign unused_sink = ^{stim_q, stim_next, cap_q, cap_sout};

  // FSM sequencing and phase counter; abort outside IDLE overrides everything
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    stim_load  = 1'b0;
    stim_shift = 1'b0;
    resp_shift = 1'b0;
    finish     = 1'b0;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d   = ST_SHIFT_IN;
            cnt_d     = '0;
            stim_load = 1'b1;
            exp_d     = expected;
          end
        end
        ST_SHIFT_IN: begin
          stim_shift = 1'b1;
          if (cnt_q == LAST_SHIFT) begin
            state_d = ST_CAPTURE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_CAPTURE: begin
          if (cnt_q == LAST_CAP) begin
            state_d = ST_SHIFT_OUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_SHIFT_OUT: begin
          resp_shift = 1'b1;
          if (cnt_q == LAST_SHIFT) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            finish  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Result bookkeeping: the last shift-out sample completes the response on
  // the same edge that enters DONE, so results are visible while done is high
  always_comb begin
    pass_d   = pass_q;
    resp_d   = resp_q;
    pcount_d = pcount_q;
    fcount_d = fcount_q;
    if (finish) begin
      resp_d   = cap_next;
      pass_d   = (cap_next == exp_q);
      pcount_d = pcount_q + 8'd1;
      if ((cap_next != exp_q) && (fcount_q != 8'hFF)) begin
        fcount_d = fcount_q + 8'd1;
      end
    end
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      exp_q    <= '0;
      pass_q   <= 1'b0;
      resp_q   <= '0;
      pcount_q <= 8'd0;
      fcount_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      pass_q   <= pass_d;
      resp_q   <= resp_d;
      pcount_q <= pcount_d;
      fcount_q <= fcount_d;
    end
  end

  assign scan_en       = (state_q == ST_SHIFT_IN) || (state_q == ST_SHIFT_OUT);
  assign scan_in       = (state_q == ST_SHIFT_IN) && stim_sout;
  assign busy          = (state_q == ST_SHIFT_IN) || (state_q == ST_CAPTURE) ||
                         (state_q == ST_SHIFT_OUT);
  assign done          = (state_q == ST_DONE);
  assign pass          = pass_q;
  assign response      = resp_q;
  assign pattern_count = pcount_q;
  assign fail_count    = fcount_q;

endmodule : scan_tester
`default_nettype wire

// File: tb/tb_scan_tester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_tester
//  Purpose  : Self-checking bench for scan_tester. The target chain is a
//             CHAIN_LEN shift register whose functional capture loads
//             {a&b, a^b}; expected results come from that rule directly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scan_tester;

  localparam int L     = 2;
  localparam int C     = 1;
  localparam int BOUND = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [L-1:0] pattern;
  logic [L-1:0] expected;
  logic         scan_en;
  logic         scan_in;
  logic         scan_out;
  logic         busy;
  logic         done;
  logic         pass;
  logic [L-1:0] response;
  logic [7:0]   pattern_count;
  logic [7:0]   fail_count;

  logic [L-1:0] chain;
  logic         cap_a;
  logic         cap_b;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           m_pc;
  int           m_fc;
  logic         m_pass;
  logic [L-1:0] m_resp;

  scan_tester #(.CHAIN_LEN(L), .CAP_CYCLES(C)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .pattern       (pattern),
    .expected      (expected),
    .scan_en       (scan_en),
    .scan_in       (scan_in),
    .scan_out      (scan_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .response      (response),
    .pattern_count (pattern_count),
    .fail_count    (fail_count)
  );

  always #5 clk = ~clk;

  // Target chain: shifts when scan-enabled, otherwise captures {a&b, a^b}
  always @(posedge clk) begin
    if (scan_en) chain <= {chain[L-2:0], scan_in};
    else         chain <= {cap_a & cap_b, cap_a ^ cap_b};
  end
  assign scan_out = chain[L-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_pc = 0;
    m_fc = 0;
    m_pass = 1'b0;
    m_resp = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_scan_en"}, scan_en, 0);
    chk({tag, "_scan_in"}, scan_in, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_response"}, response, 0);
    chk({tag, "_pattern_count"}, pattern_count, 0);
    chk({tag, "_fail_count"}, fail_count, 0);
  endtask

  // One full test; restart_cyc>0 pulses start again in that cycle
  task automatic run_test(input logic [L-1:0] pat, input logic [L-1:0] exp_v,
                          input logic a, input logic b, input int restart_cyc);
    logic [L-1:0] seq;
    int           nsi;
    int           cyc;
    int           done_cyc;
    pattern  = pat;
    expected = exp_v;
    cap_a    = a;
    cap_b    = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    pattern  = ~pat;
    expected = ~exp_v;
    cyc = 1; nsi = 0; done_cyc = 0; seq = '0;
    while ((cyc <= BOUND) && (done_cyc == 0)) begin
      start = (cyc == restart_cyc);
      if (scan_en && (nsi < L)) begin
        seq = {seq[L-2:0], scan_in};
        nsi++;
      end
      if (cyc == 1) chk("busy_after_accept", busy, 1);
      if (done) begin
        done_cyc = cyc;
        chk("busy_in_done", busy, 0);
      end else begin
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    m_resp = {a & b, a ^ b};
    m_pass = (m_resp == exp_v);
    m_pc   = (m_pc + 1) % 256;
    if (!m_pass && (m_fc < 255)) m_fc++;
    chk("done_latency", done_cyc, 2 * L + C + 1);
    chk("scan_in_seq", seq, pat);
    chk("response", response, m_resp);
    chk("pass", pass, m_pass);
    chk("pattern_count", pattern_count, m_pc);
    chk("fail_count", fail_count, m_fc);
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  // Watch n cycles and return how many had done high
  task automatic count_dones(input int n, output int nd);
    nd = 0;
    for (int i = 0; i < n; i++) begin
      if (done) nd++;
      tick();
    end
  endtask

  initial begin
    int nd;
    logic [L-1:0] rp;
    logic [L-1:0] re;
    logic         ra;
    logic         rb;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = '0; expected = '0; cap_a = 1'b0; cap_b = 1'b0;
    do_reset();
    chk_reset_outputs("reset");

    // Pass case: pattern 10, capture a=1 b=1, expected 10
    run_test(2'b10, 2'b10, 1'b1, 1'b1, 0);

    // Fail case from a fresh reset: capture a=0 b=1 gives 01
    do_reset();
    run_test(2'b10, 2'b10, 1'b0, 1'b1, 0);
    chk("fail_case_fail_count", fail_count, 1);
    chk("fail_case_pattern_count", pattern_count, 1);

    // Randomised tests; half the time the golden value is the true response
    for (int i = 0; i < 12; i++) begin
      rp = L'($urandom);
      ra = 1'($urandom);
      rb = 1'($urandom);
      re = ($urandom_range(0, 1) == 1) ? {ra & rb, ra ^ rb} : L'($urandom);
      run_test(rp, re, ra, rb, 0);
    end

    // start re-pulsed in the first SHIFT_OUT cycle must not queue a test
    run_test(2'b01, 2'b11, 1'b1, 1'b0, L + C + 1);
    count_dones(2 * L + C + 4, nd);
    chk("no_queued_done", nd, 0);
    chk("no_queued_busy", busy, 0);
    chk("no_queued_pattern_count", pattern_count, m_pc);

    // Abort during CAPTURE
    pattern = 2'b11; expected = 2'b00; cap_a = 1'b0; cap_b = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (L) tick();
    chk("in_capture_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_scan_en", scan_en, 0);
    chk("abort_busy", busy, 0);
    count_dones(2 * L + C + 3, nd);
    chk("abort_no_done", nd, 0);
    chk("abort_pass_kept", pass, m_pass);
    chk("abort_response_kept", response, m_resp);
    chk("abort_pattern_count_kept", pattern_count, m_pc);
    chk("abort_fail_count_kept", fail_count, m_fc);
    run_test(2'b11, 2'b00, 1'b0, 1'b0, 0);

    // abort together with start in IDLE: abort wins
    pattern = 2'b10; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_busy", busy, 0);
    chk("abort_start_idle_scan_en", scan_en, 0);

    // Reset during SHIFT_IN after a passing test left non-zero results
    run_test(2'b10, 2'b10, 1'b1, 1'b1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pre_reset_scan_en", scan_en, 1);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midtest_reset");
    rst = 1'b0;
    m_pc = 0; m_fc = 0; m_pass = 1'b0; m_resp = '0;

    // 256 failing tests: pattern_count wraps to 0, fail_count holds 255
    for (int i = 0; i < 256; i++) begin
      run_test(2'b00, 2'b10, 1'b1, 1'b0, 0);
    end
    chk("wrap_pattern_count", pattern_count, 0);
    chk("saturate_fail_count", fail_count, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_scan_tester
`default_nettype wire
